// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: owns the fetch PC, drives the single-cycle instruction
// SRAM port and buffers {pc, inst} pairs in a DEPTH-entry FIFO drained by decode.
module inst_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'hBFC00000,
  localparam int         CW       = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  output logic          inst_sram_en,
  output logic [3:0]    inst_sram_wen,
  output logic [31:0]   inst_sram_addr,
  output logic [31:0]   inst_sram_wdata,
  input  logic [31:0]   inst_sram_rdata,
  input  logic          flush,
  input  logic [31:0]   flush_pc,
  input  logic          deq_ready,
  output logic          deq_valid,
  output logic [31:0]   deq_pc,
  output logic [31:0]   deq_inst,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [31:0]   pc_q;
  logic [31:0]   inflight_pc_q;
  logic          inflight_q;
  logic [31:0]   fifo_pc   [DEPTH];
  logic [31:0]   fifo_inst [DEPTH];
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [CW-1:0] count_q;

  logic [CW:0]   occupancy;
  logic          issue;
  logic          enq;
  logic          deq;
  logic          empty;

  // A read is only issued when its response is guaranteed a free slot.
  assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign issue     = resetn & ~flush & (occupancy < (CW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign enq       = inflight_q & ~flush;
  assign deq       = ~empty & deq_ready & ~flush;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
    end else if (flush) begin
      pc_q       <= flush_pc;
      inflight_q <= 1'b0;
      head_q     <= tail_q;
      count_q    <= '0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        inflight_pc_q <= pc_q;
        pc_q          <= pc_q + 32'd4;
      end
      if (enq) tail_q <= tail_q + PW'(1);
      if (deq) head_q <= head_q + PW'(1);
      case ({enq, deq})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_pc[tail_q]   <= inflight_pc_q;
      fifo_inst[tail_q] <= inst_sram_rdata;
    end
  end

  assign inst_sram_en    = issue;
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_addr  = pc_q;
  assign inst_sram_wdata = 32'h0;

  assign deq_valid = ~empty;
  assign deq_pc    = empty ? 32'h0 : fifo_pc[head_q];
  assign deq_inst  = empty ? 32'h0 : fifo_inst[head_q];
  assign count     = count_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue (DEPTH=4) with a one-cycle SRAM model
// returning addr ^ 32'h5A5A5A5A.
module tb_inst_fetch_queue;
  localparam logic [31:0] MASK = 32'h5A5A5A5A;
  localparam logic [31:0] RPC  = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata = 32'h0;
  logic        flush;
  logic [31:0] flush_pc;
  logic        deq_ready;
  logic        deq_valid;
  logic [31:0] deq_pc;
  logic [31:0] deq_inst;
  logic [2:0]  count;

  int n_tests = 0;
  int n_fail  = 0;

  inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'hBFC00000)) dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_en(inst_sram_en), .inst_sram_wen(inst_sram_wen),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata),
    .flush(flush), .flush_pc(flush_pc),
    .deq_ready(deq_ready), .deq_valid(deq_valid),
    .deq_pc(deq_pc), .deq_inst(deq_inst), .count(count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (inst_sram_en) inst_sram_rdata <= inst_sram_addr ^ MASK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    #2 resetn = 1'b0;
    cyc();
    resetn = 1'b1;
    #1;
  endtask

  int          n_en;
  int          n_deq;
  logic [31:0] exp_pc;

  initial begin
    resetn    = 1'b0;
    flush     = 1'b0;
    flush_pc  = 32'h0;
    deq_ready = 1'b1;

    // reset values
    cyc(); cyc();
    chk("rst_en",    32'(inst_sram_en), 32'h0);
    chk("rst_addr",  inst_sram_addr, RPC);
    chk("rst_valid", 32'(deq_valid), 32'h0);
    chk("rst_pc",    deq_pc, 32'h0);
    chk("rst_inst",  deq_inst, 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_wen",   32'(inst_sram_wen), 32'h0);
    chk("rst_wdata", inst_sram_wdata, 32'h0);

    // streaming with deq_ready high: cycle 0 issue, cycle 2 first dequeue
    resetn = 1'b1;
    #1;
    chk("c0_en",   32'(inst_sram_en), 32'h1);
    chk("c0_addr", inst_sram_addr, RPC);
    cyc();
    chk("c1_valid", 32'(deq_valid), 32'h0);
    chk("c1_addr",  inst_sram_addr, RPC + 32'd4);
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("stream_valid", 32'(deq_valid), 32'h1);
      chk("stream_pc",    deq_pc, RPC + 32'(4 * i));
      chk("stream_inst",  deq_inst, (RPC + 32'(4 * i)) ^ MASK);
      chk("stream_count", 32'(count), 32'h1);
    end

    // asynchronous reset between edges
    #2 resetn = 1'b0;
    #1;
    chk("arst_en",    32'(inst_sram_en), 32'h0);
    chk("arst_addr",  inst_sram_addr, RPC);
    chk("arst_valid", 32'(deq_valid), 32'h0);
    chk("arst_pc",    deq_pc, 32'h0);
    chk("arst_count", 32'(count), 32'h0);
    cyc();
    resetn = 1'b1;
    #1;
    cyc(); cyc();
    chk("restart_valid", 32'(deq_valid), 32'h1);
    chk("restart_pc",    deq_pc, RPC);
    chk("restart_count", 32'(count), 32'h1);

    // backpressure: exactly DEPTH reads, then drain in order
    deq_ready = 1'b0;
    pulse_reset();
    n_en = 0;
    for (int i = 0; i < 8; i++) begin
      if (inst_sram_en) n_en++;
      cyc();
    end
    chk("bp_reads", 32'(n_en), 32'd4);
    chk("bp_count", 32'(count), 32'd4);
    chk("bp_en",    32'(inst_sram_en), 32'h0);
    chk("bp_addr",  inst_sram_addr, RPC + 32'h10);
    deq_ready = 1'b1;
    #1;
    chk("drain_pc0", deq_pc, RPC);
    for (int i = 1; i < 5; i++) begin
      cyc();
      chk("drain_pc", deq_pc, RPC + 32'(4 * i));
    end

    // flush with count=3 and a read in flight
    deq_ready = 1'b0;
    pulse_reset();
    cyc(); cyc(); cyc(); cyc();
    chk("pre_flush_count", 32'(count), 32'd3);
    flush    = 1'b1;
    flush_pc = 32'h80001000;
    #1;
    chk("flush_en", 32'(inst_sram_en), 32'h0);
    cyc();
    flush = 1'b0;
    #1;
    chk("post_flush_count", 32'(count), 32'h0);
    chk("post_flush_valid", 32'(deq_valid), 32'h0);
    chk("post_flush_pc",    deq_pc, 32'h0);
    chk("post_flush_addr",  inst_sram_addr, 32'h80001000);
    chk("post_flush_en",    32'(inst_sram_en), 32'h1);
    cyc();
    chk("flush_n2_valid", 32'(deq_valid), 32'h0);
    cyc();
    chk("flush_n3_valid", 32'(deq_valid), 32'h1);
    chk("flush_n3_pc",    deq_pc, 32'h80001000);
    chk("flush_n3_count", 32'(count), 32'h1);

    // flush, dequeue and response all in one cycle; redirect near the top of memory
    deq_ready = 1'b1;
    flush     = 1'b1;
    flush_pc  = 32'hFFFFFFF8;
    #1;
    chk("fdq_en", 32'(inst_sram_en), 32'h0);
    cyc();
    flush = 1'b0;
    #1;
    chk("fdq_count", 32'(count), 32'h0);
    chk("fdq_valid", 32'(deq_valid), 32'h0);
    chk("fdq_addr",  inst_sram_addr, 32'hFFFFFFF8);
    cyc();
    chk("fdq_n2_valid", 32'(deq_valid), 32'h0);
    cyc();
    chk("wrap_pc0",   deq_pc, 32'hFFFFFFF8);
    chk("wrap_addr",  inst_sram_addr, 32'h0);
    cyc();
    chk("wrap_pc1",   deq_pc, 32'hFFFFFFFC);
    cyc();
    chk("wrap_pc2",   deq_pc, 32'h0);
    chk("wrap_inst2", deq_inst, MASK);

    // back-to-back flushes: the last target wins
    flush    = 1'b1;
    flush_pc = 32'h11110000;
    #1;
    chk("ff1_en", 32'(inst_sram_en), 32'h0);
    cyc();
    flush_pc = 32'h22220000;
    #1;
    chk("ff2_en", 32'(inst_sram_en), 32'h0);
    cyc();
    flush = 1'b0;
    #1;
    chk("ff_addr",  inst_sram_addr, 32'h22220000);
    chk("ff_count", 32'(count), 32'h0);

    // random backpressure: order, data and bounded occupancy
    exp_pc = 32'h22220000;
    n_deq  = 0;
    for (int i = 0; i < 400; i++) begin
      cyc();
      deq_ready = 1'($urandom_range(0, 1));
      #1;
      if (deq_valid && deq_ready) begin
        chk("rnd_pc",   deq_pc, exp_pc);
        chk("rnd_inst", deq_inst, exp_pc ^ MASK);
        exp_pc = exp_pc + 32'd4;
        n_deq++;
      end
      chk("rnd_count_le_depth", 32'(count <= 3'd4), 32'h1);
      if (count == 3'd4) chk("rnd_full_no_issue", 32'(inst_sram_en), 32'h0);
    end
    chk("rnd_progress", 32'(n_deq > 100), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
